// File: rtl/fifo_width_unpacker.sv
// Pops one wide word from a peek-mode FIFO and replays it as RATIO narrow beats
// on a valid/ready stream, flagging the final slice of each word with out_last.
module fifo_width_unpacker #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  fifo_read_data,
    input  logic                 fifo_valid,
    output logic                 fifo_rdEn,
    output logic                 fifo_peek,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    input  logic                 abort,
    output logic [15:0]          words_done
);

    localparam int RATIO    = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_BITS = $clog2(RATIO);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(RATIO - 1);

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    state_t                r_state;
    logic [IN_WIDTH-1:0]   r_hold;
    logic [CNT_BITS-1:0]   r_cnt;
    logic [15:0]           r_words_done;

    logic                  w_hs;
    logic                  w_need;
    logic [CNT_BITS-1:0]   w_idx;
    logic [OUT_WIDTH-1:0]  w_slices [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign w_slices[g] = r_hold[g*OUT_WIDTH +: OUT_WIDTH];
    end

    if (LSB_FIRST) begin : g_lsb_first
        assign w_idx = r_cnt;
    end else begin : g_msb_first
        assign w_idx = LAST_CNT - r_cnt;
    end

    // Peeking keeps fifo_valid independent of fifo_rdEn, so the pop decision
    // below never closes a combinational loop through the FIFO empty logic.
    assign fifo_peek  = ~reset;
    assign out_valid  = (r_state == ST_LOADED) & ~reset;
    assign out_last   = out_valid & (r_cnt == LAST_CNT);
    assign out_data   = w_slices[w_idx];
    assign words_done = r_words_done;

    assign w_hs      = out_valid & out_ready;
    assign w_need    = (r_state == ST_EMPTY) | (w_hs & out_last);
    assign fifo_rdEn = ~reset & ~abort & fifo_valid & w_need;

    // NOTE: non-blocking assignments throughout so every branch sees the
    // pre-edge state; the hold register is reset too, purely for determinism.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_words_done <= '0;
        end else if (abort) begin
            r_state <= ST_EMPTY;
            r_cnt   <= '0;
        end else if (w_hs) begin
            if (out_last) begin
                r_words_done <= r_words_done + 16'd1;
                r_cnt        <= '0;
                if (fifo_rdEn) begin
                    r_hold <= fifo_read_data;
                end else begin
                    r_state <= ST_EMPTY;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if ((r_state == ST_EMPTY) && fifo_rdEn) begin
            r_hold  <= fifo_read_data;
            r_cnt   <= '0;
            r_state <= ST_LOADED;
        end
    end

endmodule

// File: tb/tb_fifo_width_unpacker.sv
// Directed bench: a small FIFO model feeds the LSB-first unpacker while a
// scoreboard monitor checks every accepted beat; a second MSB-first instance covers back-pressure.
module tb_fifo_width_unpacker;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fifo_read_data;
    logic        fifo_valid;
    logic        fifo_rdEn;
    logic        fifo_peek;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        abort;
    logic [15:0] words_done;

    logic [31:0] m_read_data;
    logic        m_fifo_valid;
    logic        m_rdEn;
    logic        m_peek;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] m_words_done;

    logic [31:0] fq[$];
    beat_t       exp_q[$];
    logic        byp_wr;
    logic [31:0] byp_data;
    int          rd_count;
    int          rd_on_last;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fifo_width_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_read_data (fifo_read_data),
        .fifo_valid     (fifo_valid),
        .fifo_rdEn      (fifo_rdEn),
        .fifo_peek      (fifo_peek),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .abort          (abort),
        .words_done     (words_done)
    );

    fifo_width_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk            (clk),
        .reset          (reset),
        .fifo_read_data (m_read_data),
        .fifo_valid     (m_fifo_valid),
        .fifo_rdEn      (m_rdEn),
        .fifo_peek      (m_peek),
        .out_data       (m_data),
        .out_valid      (m_valid),
        .out_ready      (m_ready),
        .out_last       (m_last),
        .abort          (1'b0),
        .words_done     (m_words_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_valid     = (fq.size() > 0) || byp_wr;
        fifo_read_data = (fq.size() > 0) ? fq[0] : byp_data;
    endtask

    task automatic exp_beats(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back('{data: b0, last: 1'b0});
        exp_q.push_back('{data: b1, last: 1'b0});
        exp_q.push_back('{data: b2, last: 1'b0});
        exp_q.push_back('{data: b3, last: 1'b1});
    endtask

    // One clock: sample the pop request away from the edge, then retire the
    // popped word (or the bypass write) from the FIFO model after the edge.
    task automatic tick();
        logic rd;
        logic was_empty;
        @(negedge clk);
        rd = fifo_rdEn;
        if (rd) rd_count++;
        if (rd && out_valid && out_ready && out_last) rd_on_last++;
        @(posedge clk);
        #1;
        was_empty = (fq.size() == 0);
        if (rd && !was_empty) void'(fq.pop_front());
        if (byp_wr && !(rd && was_empty)) fq.push_back(byp_data);
        byp_wr = 1'b0;
        refresh();
    endtask

    task automatic drain(input int max_cycles, output int cycles);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < max_cycles) begin
            tick();
            cycles++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && !abort && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got %h, none expected", out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e.data));
                check("beat_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          cycles;
        int          hs;
        logic [15:0] wd0;
        logic [7:0]  t3_data [7] = '{8'hDE, 8'hAD, 8'hAD, 8'hAD, 8'hBE, 8'hEF, 8'hEF};
        logic        t3_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        t3_rdy  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; out_ready = 1'b1; abort = 1'b0;
        byp_wr = 1'b0; byp_data = '0;
        m_read_data = '0; m_fifo_valid = 1'b0; m_ready = 1'b0;
        rd_count = 0; rd_on_last = 0;
        fq.push_back(32'h0BAD0BAD);
        refresh();
        repeat (3) begin @(posedge clk); #1; end
        check("rst_peek",      32'(fifo_peek),  32'd0);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_rdEn",      32'(fifo_rdEn),  32'd0);
        check("rst_words",     32'(words_done), 32'd0);
        fq.delete();
        refresh();
        reset = 1'b0;
        #1;
        check("peek_after_rst",  32'(fifo_peek), 32'd1);
        check("valid_after_rst", 32'(out_valid), 32'd0);

        // 1: single word, LSB first, one pop, four consecutive beats
        rd_count = 0;
        fq.push_back(32'hA1B2C3D4); refresh();
        exp_beats(8'hD4, 8'hC3, 8'hB2, 8'hA1);
        drain(20, cycles);
        check("t1_cycles", 32'(cycles),     32'd5);
        check("t1_pops",   32'(rd_count),   32'd1);
        check("t1_words",  32'(words_done), 32'd1);

        // 2: two words back to back, second pop on the last-beat handshake
        rd_count = 0; rd_on_last = 0;
        fq.push_back(32'h11223344); fq.push_back(32'h55667788); refresh();
        exp_beats(8'h44, 8'h33, 8'h22, 8'h11);
        exp_beats(8'h88, 8'h77, 8'h66, 8'h55);
        drain(30, cycles);
        check("t2_cycles",  32'(cycles),     32'd9);
        check("t2_pops",    32'(rd_count),   32'd2);
        check("t2_pop_hs",  32'(rd_on_last), 32'd1);
        check("t2_words",   32'(words_done), 32'd3);

        // 3: MSB-first instance under back-pressure
        m_fifo_valid = 1'b1; m_read_data = 32'hDEADBEEF;
        @(negedge clk);
        check("t3_pop", 32'(m_rdEn), 32'd1);
        @(posedge clk); #1;
        m_fifo_valid = 1'b0;
        hs = 0;
        for (int i = 0; i < 7; i++) begin
            m_ready = t3_rdy[i];
            @(negedge clk);
            check("t3_valid", 32'(m_valid), 32'd1);
            check("t3_data",  32'(m_data),  32'(t3_data[i]));
            check("t3_last",  32'(m_last),  32'(t3_last[i]));
            if (m_valid && m_ready) hs++;
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        check("t3_hs",       32'(hs),           32'd4);
        check("t3_idle",     32'(m_valid),      32'd0);
        check("t3_words",    32'(m_words_done), 32'd1);

        // 4: FIFO bypass write captured while the adapter is empty
        rd_count = 0;
        byp_wr = 1'b1; byp_data = 32'hCAFEF00D; refresh();
        exp_beats(8'h0D, 8'hF0, 8'hFE, 8'hCA);
        drain(20, cycles);
        check("t4_cycles",   32'(cycles),     32'd5);
        check("t4_pops",     32'(rd_count),   32'd1);
        check("t4_fifo_emp", 32'(fifo_valid), 32'd0);
        check("t4_words",    32'(words_done), 32'd4);

        // 5: abort after the second beat; next word restarts at its first slice
        rd_count = 0;
        wd0 = words_done;
        fq.push_back(32'h01020304); fq.push_back(32'h0A0B0C0D); refresh();
        exp_q.push_back('{data: 8'h04, last: 1'b0});
        exp_q.push_back('{data: 8'h03, last: 1'b0});
        repeat (3) tick();
        check("t5_pre_left", 32'(exp_q.size()), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("t5_valid_off", 32'(out_valid),  32'(1'b0));
        check("t5_words",     32'(words_done), 32'(wd0));
        check("t5_pops",      32'(rd_count),   32'd1);
        exp_beats(8'h0D, 8'h0C, 8'h0B, 8'h0A);
        drain(20, cycles);
        check("t5_cycles",  32'(cycles),     32'd5);
        check("t5_words2",  32'(words_done), 32'(wd0 + 16'd1));

        // 6: reset after one beat discards the partial word
        fq.push_back(32'h99AABBCC); refresh();
        exp_q.push_back('{data: 8'hCC, last: 1'b0});
        repeat (2) tick();
        fq.push_back(32'h13579BDF); refresh();
        reset = 1'b1;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_last",  32'(out_last),  32'd0);
        check("t6_rdEn",  32'(fifo_rdEn), 32'd0);
        check("t6_peek",  32'(fifo_peek), 32'd0);
        repeat (2) tick();
        check("t6_words",    32'(words_done), 32'd0);
        check("t6_not_pop",  32'(fq.size()),  32'd1);
        reset = 1'b0;
        exp_beats(8'hDF, 8'h9B, 8'h57, 8'h13);
        drain(20, cycles);
        check("t6_cycles", 32'(cycles),     32'd5);
        check("t6_words2", 32'(words_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_width_unpacker.md
Name: fifo_width_unpacker

Overview:
- Downstream consumer of the common FIFO. Pops one wide word from the FIFO and emits it as RATIO narrow beats on a valid/ready stream, with a last flag on the final beat.
- Sits between a wide FIFO and narrow-datapath consumers, for example byte-serial peripherals.
- Supports back-to-back words with no bubble, and an abort input that discards the word in flight.

Parameters:
- IN_WIDTH, 32: FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8: output beat width.
- LSB_FIRST, 1: 1 emits the least-significant slice first; 0 emits the most-significant slice first.
- Derived localparams: RATIO = IN_WIDTH/OUT_WIDTH (must be >= 2); CNT_BITS = clog2(RATIO).

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- fifo_read_data, input, IN_WIDTH: FIFO read_data.
- fifo_valid, input, 1: FIFO valid.
- fifo_rdEn, output, 1: FIFO pop request.
- fifo_peek, output, 1: FIFO peek request.
- out_data, output, OUT_WIDTH: current beat.
- out_valid, output, 1: beat available.
- out_ready, input, 1: consumer accepts the beat.
- out_last, output, 1: current beat is the final slice of its word.
- abort, input, 1: drop the word in flight.
- words_done, output, 16: count of fully emitted words; wraps modulo 2^16.

Behaviour:
- Clock is clk; reset is synchronous, active-high, named reset.
- fifo_peek = ~reset. This makes FIFO valid independent of fifo_rdEn.
  - Pop decisions use fifo_valid only, never the FIFO empty flag. That flag depends combinationally on rdEn and would form a loop.
- State: holding register hold[IN_WIDTH], beat counter cnt[CNT_BITS], state bit LOADED (0 = EMPTY).
- Reset values: LOADED=0, cnt=0, hold=0, words_done=0.
  - During reset: out_valid=0, out_last=0, fifo_rdEn=0, fifo_peek=0.
- need = ~LOADED | (out_valid & out_ready & out_last).
- fifo_rdEn = ~reset & ~abort & fifo_valid & need. This is combinational; the word is captured into hold on the same edge.
- out_valid = LOADED. out_last = LOADED & (cnt == RATIO-1).
- out_data:
  - LSB_FIRST=1: hold[cnt*OUT_WIDTH +: OUT_WIDTH].
  - LSB_FIRST=0: hold[(RATIO-1-cnt)*OUT_WIDTH +: OUT_WIDTH].
  - Driven from registers only; there is no combinational path from fifo_read_data to out_data.
- Handshake (out_valid & out_ready):
  - Not last beat: cnt <= cnt+1.
  - Last beat: words_done <= words_done+1 and cnt <= 0.
    - If fifo_rdEn, then hold <= fifo_read_data and LOADED stays 1 (no bubble).
    - Otherwise LOADED <= 0.
- EMPTY & fifo_rdEn: hold <= fifo_read_data, cnt <= 0, LOADED <= 1. The first beat is valid the next cycle.
- out_valid, once high, holds with stable out_data until accepted. Deasserting out_ready freezes cnt.
- abort (priority over the handshake):
  - LOADED <= 0, cnt <= 0, no pop that cycle, words_done unchanged.
  - Any beat accepted in the same cycle is treated as lost.
- FIFO bypass: when the FIFO is bare but being written, its read_data is the write data and fifo_valid=1. Popping then is legal and the word is captured normally.
- Latency: one cycle from fifo_valid (while EMPTY) to the first out_valid. Steady-state throughput is one beat per cycle.
- Reset mid-word: the partial word is discarded; nothing already popped is re-read.

Test Plan:
1. Reset, then FIFO holds 0xA1B2C3D4, out_ready=1, LSB_FIRST=1:
   - One fifo_rdEn pulse.
   - Beats D4, C3, B2, A1 on four consecutive cycles; out_last only on A1.
   - words_done=1.
2. Two words 0x11223344 and 0x55667788, out_ready=1:
   - 8 contiguous beats 44,33,22,11,88,77,66,55 with no out_valid gap.
   - Second fifo_rdEn coincides with the handshake of beat 11.
3. Back-pressure, LSB_FIRST=0, word 0xDEADBEEF:
   - Toggle out_ready 1,0,0,1,1,0,1.
   - Sequence is DE, AD, BE, EF; out_data stable while out_ready=0; exactly 4 handshakes.
4. FIFO bypass: FIFO empty, write 0xCAFEF00D in the same cycle the adapter is EMPTY:
   - fifo_rdEn=1 that cycle; beats 0D, F0, FE, CA follow; the FIFO stays empty.
5. abort after the second beat of 0x01020304:
   - out_valid=0 next cycle; no further beats of that word; words_done unchanged.
   - The next FIFO word starts at cnt=0.
6. reset asserted mid-word (after 1 beat):
   - out_valid=0, fifo_rdEn=0, fifo_peek=0, words_done=0.
   - After release, the next FIFO word emits all 4 beats.
